// File: rtl/fetch_stage_if.sv
// Fetch stage bus bundle: the rom port, the redirect request from execute and
// the valid/ready hand-off to decode.
// master: the fetch stage side. slave: the surrounding rom/execute/decode side.
// FETCH_MISALIGN_EN adds the out_misaligned flag next to the decode payload.
interface fetch_stage_if;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef FETCH_MISALIGN_EN
    logic        out_misaligned;

    modport master (
        output rom_addr,
        input  rom_data,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output out_misaligned
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  out_misaligned
    );
`else
    modport master (
        output rom_addr,
        input  rom_data,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );
`endif
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage for the rv32i pipeline.
// Owns the PC, addresses the synchronous-read rom, tags each returned word
// with its PC and hands {instr, pc} to decode. A small buffer absorbs decode
// backpressure; a credit check stops issue before the buffer could overflow,
// and a redirect from execute flushes everything in flight.
// Optional feature macro: FETCH_MISALIGN_EN
//   defined   : misaligned redirect targets are fetched once, flagged on
//               out_misaligned, and issue halts until the next redirect.
//   undefined : redirect targets are truncated to a word boundary.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input logic           clock,
    input logic           reset_n,
    fetch_stage_if.master bus
);

    localparam int PW = (BUF_DEPTH > 2) ? 2 : 1;
    localparam int CW = 3;

    logic [31:0]   pc_q, pc_d;
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [31:0]   fifo_instr_q [BUF_DEPTH];
    logic [31:0]   fifo_pc_q    [BUF_DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    logic [31:0]   last_instr_q, last_pc_q;

    logic [31:0]   redir_tgt;
    logic          buf_nonempty;
    logic          out_valid;
    logic [31:0]   sel_instr, sel_pc;
    logic          pop, buf_pop, push;
    logic [CW:0]   occupancy;
    logic          issue_ok;
    logic          halted;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef FETCH_MISALIGN_EN
    logic halt_q, halt_d;
    assign redir_tgt = bus.redirect_pc;
    assign halted    = halt_q;
`else
    assign redir_tgt = bus.redirect_pc & ~32'h3;
    assign halted    = 1'b0;
`endif

    // Presented word: buffer head first, otherwise the rom word landing now.
    always_comb begin
        buf_nonempty = (count_q != '0);
        out_valid    = buf_nonempty | resp_valid_q;
        sel_instr    = buf_nonempty ? fifo_instr_q[head_q] : bus.rom_data;
        sel_pc       = buf_nonempty ? fifo_pc_q[head_q]    : resp_pc_q;
        pop          = out_valid & bus.out_ready;
        buf_pop      = pop & buf_nonempty;
        // the landing word is consumed only if it bypassed straight to decode
        push         = resp_valid_q & (buf_nonempty | ~bus.out_ready);
        occupancy    = (CW+1)'(count_q) + (CW+1)'(resp_valid_q) - (CW+1)'(pop);
        issue_ok     = (occupancy < (CW+1)'(BUF_DEPTH));
    end

    assign bus.rom_addr  = bus.redirect_valid ? redir_tgt : pc_q;
    assign bus.out_valid = out_valid;
    assign bus.out_instr = out_valid ? sel_instr : last_instr_q;
    assign bus.out_pc    = out_valid ? sel_pc    : last_pc_q;
`ifdef FETCH_MISALIGN_EN
    assign bus.out_misaligned = out_valid & (sel_pc[1:0] != 2'b00);
`endif

    // Issue decision: redirect wins, otherwise issue only while credit remains.
    always_comb begin
        pc_d         = pc_q;
        resp_valid_d = 1'b0;
        resp_pc_d    = resp_pc_q;
`ifdef FETCH_MISALIGN_EN
        halt_d       = halt_q;
`endif
        if (bus.redirect_valid) begin
            pc_d         = redir_tgt + 32'd4;
            resp_valid_d = 1'b1;
            resp_pc_d    = redir_tgt;
`ifdef FETCH_MISALIGN_EN
            halt_d       = (redir_tgt[1:0] != 2'b00);
`endif
        end else if (issue_ok && !halted) begin
            pc_d         = pc_q + 32'd4;
            resp_valid_d = 1'b1;
            resp_pc_d    = pc_q;
`ifdef FETCH_MISALIGN_EN
            halt_d       = (pc_q[1:0] != 2'b00);
`endif
        end
    end

    // PC and in-flight read tracking.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q         <= RESET_PC;
            resp_valid_q <= 1'b0;
            resp_pc_q    <= '0;
`ifdef FETCH_MISALIGN_EN
            halt_q       <= 1'b0;
`endif
        end else begin
            pc_q         <= pc_d;
            resp_valid_q <= resp_valid_d;
            resp_pc_q    <= resp_pc_d;
`ifdef FETCH_MISALIGN_EN
            halt_q       <= halt_d;
`endif
        end
    end

    // Buffer pointers and occupancy; a redirect empties the buffer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (bus.redirect_valid) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push)    tail_q <= ptr_inc(tail_q);
            if (buf_pop) head_q <= ptr_inc(head_q);
            count_q <= count_q + CW'(push) - CW'(buf_pop);
        end
    end

    // Buffer storage; contents are only meaningful below count_q, so no reset.
    always_ff @(posedge clock) begin
        if (push && !bus.redirect_valid) begin
            fifo_instr_q[tail_q] <= bus.rom_data;
            fifo_pc_q[tail_q]    <= resp_pc_q;
        end
    end

    // Remember the last presented word so outputs hold while nothing is valid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_instr_q <= '0;
            last_pc_q    <= '0;
        end else if (out_valid) begin
            last_instr_q <= sel_instr;
            last_pc_q    <= sel_pc;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed vector table, randomized run against a
// stream model (decode must see target, target+4, ... after every redirect),
// reset during a full-buffer stall, and the misaligned-redirect corner.
module tb_fetch_stage;

    logic clock = 1'b0;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    always #5 clock = ~clock;

    // rom: mem[word] = word index, one cycle read latency
    always @(posedge clock) bus.rom_data <= bus.rom_addr >> 2;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        chk;
        logic        exp_v;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic [31:0] rpc, input logic rdy);
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.out_ready      = rdy;
        #1;
    endtask

    task automatic expect_word(input string name, input logic [31:0] pc);
        chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({name, "_pc"}, bus.out_pc, pc);
        chk({name, "_instr"}, bus.out_instr, pc >> 2);
    endtask

    initial begin
        logic [31:0] exp_next;
        logic        known;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;

        //            rv    rpc            rdy   chk   v     pc
        vecs[0]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0};
        vecs[2]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h4};
        vecs[3]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h8};
        vecs[4]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h8};
        vecs[5]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h8};
        vecs[6]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h8};
        vecs[7]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h8};
        vecs[8]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h8};
        vecs[9]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hC};
        vecs[10] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h10};
        vecs[11] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h14};
        vecs[12] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h14};
        vecs[13] = '{1'b1, 32'h40,       1'b0, 1'b1, 1'b1, 32'h14};
        vecs[14] = '{1'b1, 32'h60,       1'b1, 1'b1, 1'b1, 32'h40};
        vecs[15] = '{1'b1, 32'h80,       1'b0, 1'b0, 1'b0, 32'h0};
        vecs[16] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h80};
        vecs[17] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h84};
        vecs[18] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h88};
        vecs[19] = '{1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b1, 32'h8C};
        vecs[20] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8};
        vecs[21] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC};
        vecs[22] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0};
        vecs[23] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h4};

        reset_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        repeat (2) @(negedge clock);
        #1;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_pc", bus.out_pc, 32'h0);
        chk("rst_instr", bus.out_instr, 32'h0);
        chk("rst_rom_addr", bus.rom_addr, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // directed table
        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
            if (vecs[i].chk) begin
                chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_v));
                if (vecs[i].exp_v) begin
                    chk($sformatf("vec%0d_pc", i), bus.out_pc, vecs[i].exp_pc);
                    chk($sformatf("vec%0d_instr", i), bus.out_instr, vecs[i].exp_pc >> 2);
                end
            end
            @(negedge clock);
        end

        // randomized run against the stream model
        known    = 1'b0;
        exp_next = '0;
        for (int i = 0; i < 400; i++) begin
            rv  = (i == 0) || ($urandom_range(7) == 0);
            rpc = $urandom & 32'hFFFF_FFFC;
            rdy = ($urandom_range(3) != 0);
            drive(rv, rpc, rdy);
            if (known) begin
                chk("rnd_valid", 32'(bus.out_valid), 32'd1);
                chk("rnd_pc", bus.out_pc, exp_next);
                chk("rnd_instr", bus.out_instr, exp_next >> 2);
                if (rdy) exp_next = exp_next + 32'd4;
            end
            if (rv) begin
                exp_next = rpc;
                known    = 1'b1;
            end
            @(negedge clock);
        end

        // fill the buffer while stalled, then reset mid-stall
        drive(1'b1, 32'h200, 1'b0);
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b0);
            chk("stall_pc", bus.out_pc, 32'h200);
            @(negedge clock);
        end
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_pc", bus.out_pc, 32'h0);
        chk("midrst_rom_addr", bus.rom_addr, 32'h0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        drive(1'b0, 32'h0, 1'b1);
        chk("restart_valid0", 32'(bus.out_valid), 32'd0);
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b1);
            expect_word("restart", 32'(i * 4));
            @(negedge clock);
        end

        // misaligned redirect target
        drive(1'b1, 32'h42, 1'b1);
        @(negedge clock);
        drive(1'b0, 32'h0, 1'b1);
`ifdef FETCH_MISALIGN_EN
        chk("mis_valid", 32'(bus.out_valid), 32'd1);
        chk("mis_pc", bus.out_pc, 32'h42);
        chk("mis_instr", bus.out_instr, 32'h10);
        chk("mis_flag", 32'(bus.out_misaligned), 32'd1);
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b1);
            chk("mis_halt_valid", 32'(bus.out_valid), 32'd0);
            @(negedge clock);
        end
        drive(1'b1, 32'h100, 1'b1);
        chk("mis_redir_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clock);
        drive(1'b0, 32'h0, 1'b1);
        expect_word("resume0", 32'h100);
        chk("resume0_flag", 32'(bus.out_misaligned), 32'd0);
        @(negedge clock);
        drive(1'b0, 32'h0, 1'b1);
        expect_word("resume1", 32'h104);
`else
        expect_word("trunc0", 32'h40);
        @(negedge clock);
        drive(1'b0, 32'h0, 1'b1);
        expect_word("trunc1", 32'h44);
        @(negedge clock);
        drive(1'b1, 32'h100, 1'b1);
        expect_word("trunc2", 32'h48);
        @(negedge clock);
        drive(1'b0, 32'h0, 1'b1);
        expect_word("resume0", 32'h100);
`endif
        @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
